// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - register-file write-port arbiter bus bundle
interface regfile_wr_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          wb_wr_en;
  logic [4:0]    wb_wr_addr;
  logic [31:0]   wb_wr_data;
  logic          aux_valid;
  logic          aux_ready;
  logic [4:0]    aux_addr;
  logic [31:0]   aux_data;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic          rs_hazard;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [31:0]   rf_wr_data;
  logic          pipe_stall;
  logic [CW-1:0] fifo_count;

  modport master (
    output wb_wr_en, wb_wr_addr, wb_wr_data,
    output aux_valid, aux_addr, aux_data,
    output rs1, rs2,
    input  aux_ready, rs_hazard,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  pipe_stall, fifo_count
  );

  modport slave (
    input  wb_wr_en, wb_wr_addr, wb_wr_data,
    input  aux_valid, aux_addr, aux_data,
    input  rs1, rs2,
    output aux_ready, rs_hazard,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output pipe_stall, fifo_count
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - WB-priority register-file write arbiter with AUX result FIFO
module regfile_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] live_q;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [SW-1:0]    starve_q;
  logic [SW-1:0]    starve_d;

  logic wb_active;
  logic head_valid;
  logic head_live;
  logic grant_head;
  logic push;
  logic pop;
  logic push_live;
  logic hazard;

  assign wb_active  = bus.wb_wr_en && (bus.wb_wr_addr != 5'd0);
  assign head_valid = valid_q[rd_ptr_q];
  assign head_live  = live_q[rd_ptr_q];
  assign grant_head = !wb_active && head_valid && head_live;
  // Dead heads leave in one cycle whether or not WB holds the port.
  assign pop        = head_valid && (grant_head || !head_live);
  assign push       = bus.aux_valid && bus.aux_ready;
  // A same-cycle WB write to the same register is the younger value.
  assign push_live  = (bus.aux_addr != 5'd0) &&
                      !(wb_active && (bus.wb_wr_addr == bus.aux_addr));

  assign bus.aux_ready  = (count_q != CW'(DEPTH));
  assign bus.fifo_count = count_q;
  assign bus.pipe_stall = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_addr = 5'd0;
    bus.rf_wr_data = 32'd0;
    if (wb_active) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = bus.wb_wr_addr;
      bus.rf_wr_data = bus.wb_wr_data;
    end else if (grant_head) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = addr_q[rd_ptr_q];
      bus.rf_wr_data = data_q[rd_ptr_q];
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && live_q[i] &&
          (((bus.rs1 != 5'd0) && (addr_q[i] == bus.rs1)) ||
           ((bus.rs2 != 5'd0) && (addr_q[i] == bus.rs2))))
        hazard = 1'b1;
    end
  end
  assign bus.rs_hazard = hazard;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if ((count_q == CW'(0)) || grant_head)
      starve_d = '0;
    else if (head_valid && head_live && wb_active && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && wb_active && (addr_q[i] == bus.wb_wr_addr))
          live_q[i] <= 1'b0;
      end
      // Push never targets the popping slot: a full FIFO refuses pushes.
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        live_q[rd_ptr_q]  <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        live_q[wr_ptr_q]  <= push_live;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.aux_addr;
      data_q[wr_ptr_q] <= bus.aux_data;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed vector bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DEPTH(4)) bus();

  regfile_wr_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ready;
    logic        e_haz;
    logic        e_stall;
    logic [2:0]  e_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf_model [32];

  always @(posedge clk)
    if (rst && bus.rf_wr_en) rf_model[bus.rf_wr_addr] <= bus.rf_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wb_en, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    bus.wb_wr_en   = wb_en;
    bus.wb_wr_addr = wb_addr;
    bus.wb_wr_data = wb_data;
    bus.aux_valid  = av;
    bus.aux_addr   = aa;
    bus.aux_data   = ad;
    bus.rs1        = r1;
    bus.rs2        = r2;
    #1;
  endtask

  vec_t vecs [15];

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    bus.wb_wr_en = 0; bus.wb_wr_addr = 0; bus.wb_wr_data = 0;
    bus.aux_valid = 0; bus.aux_addr = 0; bus.aux_data = 0;
    bus.rs1 = 0; bus.rs2 = 0;

    vecs[0]  = '{0, 0, 0,            0, 0, 0,     0, 0,  0, 0, 0,            1, 0, 0, 0};
    vecs[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0,  1, 5, 32'hDEADBEEF, 1, 0, 0, 0};
    vecs[2]  = '{1, 0, 32'h123,      0, 0, 0,     0, 0,  0, 0, 0,            1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0,            1, 7, 32'h11, 7, 0, 0, 0, 0,            1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0,            0, 0, 0,     7, 0,  1, 7, 32'h11,       1, 1, 0, 1};
    vecs[5]  = '{0, 0, 0,            0, 0, 0,     7, 0,  0, 0, 0,            1, 0, 0, 0};
    vecs[6]  = '{1, 3, 32'h33,       1, 0, 32'h55, 0, 0, 1, 3, 32'h33,       1, 0, 0, 0};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,     0, 0,  0, 0, 0,            1, 0, 0, 1};
    vecs[8]  = '{0, 0, 0,            0, 0, 0,     0, 0,  0, 0, 0,            1, 0, 0, 0};
    vecs[9]  = '{1, 9, 32'h2,        1, 9, 32'h1, 0, 9,  1, 9, 32'h2,        1, 0, 0, 0};
    vecs[10] = '{0, 0, 0,            0, 0, 0,     0, 9,  0, 0, 0,            1, 0, 0, 1};
    vecs[11] = '{0, 0, 0,            0, 0, 0,     0, 9,  0, 0, 0,            1, 0, 0, 0};
    vecs[12] = '{0, 0, 0,            1, 4, 32'h44, 0, 0, 0, 0, 0,            1, 0, 0, 0};
    vecs[13] = '{1, 0, 32'h99,       0, 0, 0,     4, 0,  1, 4, 32'h44,       1, 1, 0, 1};
    vecs[14] = '{0, 0, 0,            0, 0, 0,     4, 0,  0, 0, 0,            1, 0, 0, 0};

    #1;
    check("reset_count", 32'(bus.fifo_count), 0);
    check("reset_ready", 32'(bus.aux_ready), 1);
    check("reset_stall", 32'(bus.pipe_stall), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data, vecs[i].av, vecs[i].aa,
            vecs[i].ad, vecs[i].r1, vecs[i].r2);
      check($sformatf("v%0d_rf_en", i),   32'(bus.rf_wr_en),   32'(vecs[i].e_en));
      check($sformatf("v%0d_rf_addr", i), 32'(bus.rf_wr_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_rf_data", i), bus.rf_wr_data,      vecs[i].e_data);
      check($sformatf("v%0d_ready", i),   32'(bus.aux_ready),  32'(vecs[i].e_ready));
      check($sformatf("v%0d_hazard", i),  32'(bus.rs_hazard),  32'(vecs[i].e_haz));
      check($sformatf("v%0d_stall", i),   32'(bus.pipe_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_count", i),   32'(bus.fifo_count), 32'(vecs[i].e_cnt));
    end
    check("vec_x9_final", rf_model[9], 32'h2);

    // Full FIFO under continuous WB traffic, then in-order drain.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i), 0, 0);
      check($sformatf("full_ready_p%0d", i), 32'(bus.aux_ready), 1);
    end
    drive(1, 1, 32'h5, 1, 14, 32'h104, 0, 0);
    check("full_ready_p4", 32'(bus.aux_ready), 0);
    check("full_count_p4", 32'(bus.fifo_count), 4);
    drive(0, 0, 0, 1, 14, 32'h104, 0, 0);
    check("drain0_addr", 32'(bus.rf_wr_addr), 10);
    check("drain0_data", bus.rf_wr_data, 32'h100);
    check("drain0_ready", 32'(bus.aux_ready), 0);
    drive(0, 0, 0, 1, 14, 32'h104, 0, 0);
    check("drain1_addr", 32'(bus.rf_wr_addr), 11);
    check("drain1_ready", 32'(bus.aux_ready), 1);
    check("drain1_count", 32'(bus.fifo_count), 3);
    for (int i = 2; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("drain%0d_en", i), 32'(bus.rf_wr_en), 1);
      check($sformatf("drain%0d_addr", i), 32'(bus.rf_wr_addr), 32'(10 + i));
      check($sformatf("drain%0d_count", i), 32'(bus.fifo_count), 32'(5 - i));
    end
    check("drain4_data", bus.rf_wr_data, 32'h104);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("drain_end_count", 32'(bus.fifo_count), 0);
    check("drain_end_en", 32'(bus.rf_wr_en), 0);

    // WAW cancel of a starved head.
    drive(1, 1, 32'h77, 1, 9, 32'h1, 0, 0);
    drive(1, 9, 32'h2, 0, 0, 0, 0, 9);
    check("waw_haz_before", 32'(bus.rs_hazard), 1);
    check("waw_wb_addr", 32'(bus.rf_wr_addr), 9);
    drive(0, 0, 0, 0, 0, 0, 0, 9);
    check("waw_haz_after", 32'(bus.rs_hazard), 0);
    check("waw_dead_no_write", 32'(bus.rf_wr_en), 0);
    check("waw_dead_count", 32'(bus.fifo_count), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("waw_popped", 32'(bus.fifo_count), 0);
    check("waw_x9_final", rf_model[9], 32'h2);

    // Starvation: stall appears after eight denied cycles, clears after a grant.
    drive(1, 2, 32'h22, 1, 20, 32'hAA, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 2, 32'h22, 0, 0, 0, 0, 0);
      check($sformatf("starve_c%0d_stall", i), 32'(bus.pipe_stall), (i >= 9) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("starve_grant_addr", 32'(bus.rf_wr_addr), 20);
    check("starve_grant_stall", 32'(bus.pipe_stall), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("starve_release", 32'(bus.pipe_stall), 0);
    check("starve_count", 32'(bus.fifo_count), 0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h0, 1, 5'(21 + i), 32'(i), 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("pre_reset_count", 32'(bus.fifo_count), 3);
    #1 rst = 1'b0;
    #1;
    check("async_count", 32'(bus.fifo_count), 0);
    check("async_rf_en", 32'(bus.rf_wr_en), 0);
    check("async_ready", 32'(bus.aux_ready), 1);
    check("async_stall", 32'(bus.pipe_stall), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("post_reset_count", 32'(bus.fifo_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
